uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 107 ++++++++++
 tb/tb_uart_tx_fifo.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter with configurable
// data bits, parity and stop bits; frames are sent back to back while data is queued.
module uart_tx_fifo #(
  parameter int CLK_HZ     = 12_000_000,
  parameter int BIT_RATE   = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          WR,
  input  logic [7:0]                    DATA,
  output logic                          TX,
  output logic                          BUSY,
  output logic                          FULL,
  output logic                          EMPTY,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
  output logic                          OVERRUN
);
  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int CW = $clog2(CPB + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic HAS_PAR = PARITY != 0;
  localparam logic ODD = PARITY == 1;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
  state_t st;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] sh, head;
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [2:0] bidx;
  logic [LW-1:0] lvl_nxt;
  logic par, bit_end, wr_ok, pop;
  assign head = mem[rp];
  assign bit_end = cnt == CW'(CPB - 1);
  assign wr_ok = WR && !FULL;
  // pop either from idle or right at the end of the last stop bit, so queued frames follow with no gap
  assign pop = !EMPTY && (st == S_IDLE || (st == S_STOP && bit_end && bidx == 3'(STOP_BITS - 1)));
  assign lvl_nxt = LEVEL + LW'(wr_ok) - LW'(pop);
  assign BUSY = st != S_IDLE || !EMPTY;
  always_ff @(posedge CLK)
    if (wr_ok) mem[wp] <= DATA[DATA_BITS-1:0];
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      wp <= '0;
      rp <= '0;
      LEVEL <= '0;
      FULL <= 1'b0;
      EMPTY <= 1'b1;
      OVERRUN <= 1'b0;
    end else begin
      wp <= wp + AW'(wr_ok);
      rp <= rp + AW'(pop);
      LEVEL <= lvl_nxt;
      FULL <= lvl_nxt == LW'(FIFO_DEPTH);
      EMPTY <= lvl_nxt == '0;
      OVERRUN <= OVERRUN | (WR && FULL);
    end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      st <= S_IDLE;
      TX <= 1'b1;
      cnt <= '0;
      bidx <= '0;
      sh <= '0;
      par <= 1'b0;
    end else if (pop) begin
      st <= S_START;
      TX <= 1'b0;
      cnt <= '0;
      bidx <= '0;
      sh <= head;
      par <= ^head;
    end else if (st != S_IDLE) begin
      cnt <= bit_end ? '0 : cnt + 1'b1;
      if (bit_end)
        case (st)
          S_START: begin
            st <= S_DATA;
            TX <= sh[0];
          end
          S_DATA: begin
            if (bidx == 3'(DATA_BITS - 1)) begin
              bidx <= '0;
              st <= HAS_PAR ? S_PAR : S_STOP;
              TX <= HAS_PAR ? par ^ ODD : 1'b1;
            end else begin
              bidx <= bidx + 1'b1;
              sh <= sh >> 1;
              TX <= sh[1];
            end
          end
          S_PAR: begin
            st <= S_STOP;
            TX <= 1'b1;
          end
          S_STOP: begin
            st <= bidx == 3'(STOP_BITS - 1) ? S_IDLE : S_STOP;
            bidx <= bidx == 3'(STOP_BITS - 1) ? '0 : bidx + 1'b1;
          end
          default: st <= S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of framing, FIFO flags, overflow and reset
// on four instances (8N1, 7E2, 5O1, 8N1 with a 4-deep FIFO), CPB=12.
module tb_uart_tx_fifo;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic rst_n [4];
  logic wr [4];
  logic [7:0] din [4];
  logic tx [4], busy [4], full [4], empty [4], ovr [4];
  logic [4:0] lv0, lv1, lv2;
  logic [2:0] lv3;
  int nchk = 0;
  int nerr = 0;
  uart_tx_fifo #(.CLK_HZ(12_000_000), .BIT_RATE(1_000_000)) u0 (
    .CLK(CLK), .RST_N(rst_n[0]), .WR(wr[0]), .DATA(din[0]), .TX(tx[0]), .BUSY(busy[0]),
    .FULL(full[0]), .EMPTY(empty[0]), .LEVEL(lv0), .OVERRUN(ovr[0]));
  uart_tx_fifo #(.CLK_HZ(12_000_000), .BIT_RATE(1_000_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u1 (
    .CLK(CLK), .RST_N(rst_n[1]), .WR(wr[1]), .DATA(din[1]), .TX(tx[1]), .BUSY(busy[1]),
    .FULL(full[1]), .EMPTY(empty[1]), .LEVEL(lv1), .OVERRUN(ovr[1]));
  uart_tx_fifo #(.CLK_HZ(12_000_000), .BIT_RATE(1_000_000), .DATA_BITS(5), .PARITY(1)) u2 (
    .CLK(CLK), .RST_N(rst_n[2]), .WR(wr[2]), .DATA(din[2]), .TX(tx[2]), .BUSY(busy[2]),
    .FULL(full[2]), .EMPTY(empty[2]), .LEVEL(lv2), .OVERRUN(ovr[2]));
  uart_tx_fifo #(.CLK_HZ(12_000_000), .BIT_RATE(1_000_000), .FIFO_DEPTH(4)) u3 (
    .CLK(CLK), .RST_N(rst_n[3]), .WR(wr[3]), .DATA(din[3]), .TX(tx[3]), .BUSY(busy[3]),
    .FULL(full[3]), .EMPTY(empty[3]), .LEVEL(lv3), .OVERRUN(ovr[3]));
  function automatic int lvl(int d);
    return d == 0 ? int'(lv0) : d == 1 ? int'(lv1) : d == 2 ? int'(lv2) : int'(lv3);
  endfunction
  task automatic chk(string tag, int got, int exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic wr1(int d, logic [7:0] b);
    din[d] = b;
    wr[d] = 1'b1;
    @(negedge CLK);
    wr[d] = 1'b0;
  endtask
  // entered on the negedge right after the start edge; returns on the negedge before the frame's end edge
  task automatic frame(int d, logic [15:0] exp, int nb, string tag);
    chk({tag, "_start"}, int'(tx[d]), 0);
    repeat (6) @(negedge CLK);
    for (int k = 0; k < nb; k++) begin
      chk($sformatf("%s_bit%0d", tag, k), int'(tx[d]), int'(exp[k]));
      if (k < nb - 1) repeat (12) @(negedge CLK);
    end
    repeat (5) @(negedge CLK);
    chk({tag, "_lastcyc_busy"}, int'(busy[d]), 1);
    chk({tag, "_lastcyc_tx"}, int'(tx[d]), 1);
  endtask
  task automatic single(int d, logic [7:0] b, logic [15:0] exp, int nb, string tag);
    wr1(d, b);
    chk({tag, "_pre_tx"}, int'(tx[d]), 1);
    chk({tag, "_pre_level"}, lvl(d), 1);
    @(negedge CLK);
    frame(d, exp, nb, tag);
    @(negedge CLK);
    chk({tag, "_end_busy"}, int'(busy[d]), 0);
    chk({tag, "_end_tx"}, int'(tx[d]), 1);
    chk({tag, "_end_level"}, lvl(d), 0);
    chk({tag, "_end_empty"}, int'(empty[d]), 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int lows;
    int lv_exp [6] = '{1, 1, 2, 3, 4, 4};
    int fu_exp [6] = '{0, 0, 0, 0, 1, 1};
    for (int d = 0; d < 4; d++) begin
      rst_n[d] = 1'b0;
      wr[d] = 1'b0;
      din[d] = 8'h00;
    end
    repeat (2) @(negedge CLK);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst%0d_tx", d), int'(tx[d]), 1);
      chk($sformatf("rst%0d_busy", d), int'(busy[d]), 0);
      chk($sformatf("rst%0d_empty", d), int'(empty[d]), 1);
      chk($sformatf("rst%0d_full", d), int'(full[d]), 0);
      chk($sformatf("rst%0d_level", d), lvl(d), 0);
      chk($sformatf("rst%0d_ovr", d), int'(ovr[d]), 0);
      rst_n[d] = 1'b1;
    end
    repeat (2) @(negedge CLK);
    // back to back: second byte written on the first pop edge, so LEVEL stays 1 there
    din[0] = 8'h55;
    wr[0] = 1'b1;
    @(negedge CLK);
    chk("b2b_level_w1", lvl(0), 1);
    din[0] = 8'hAA;
    @(negedge CLK);
    wr[0] = 1'b0;
    chk("b2b_level_w2", lvl(0), 1);
    frame(0, {1'b1, 8'h55, 1'b0}, 10, "b2b_a");
    @(negedge CLK);
    chk("b2b_level_pop2", lvl(0), 0);
    frame(0, {1'b1, 8'hAA, 1'b0}, 10, "b2b_b");
    @(negedge CLK);
    chk("b2b_end_busy", int'(busy[0]), 0);
    chk("b2b_end_tx", int'(tx[0]), 1);
    repeat (3) @(negedge CLK);
    // reset mid-frame with 3 queued, at cycle 50 (data bit 3 of 0x00, line low)
    din[0] = 8'h00;
    wr[0] = 1'b1;
    repeat (4) @(negedge CLK);
    wr[0] = 1'b0;
    chk("mid_level_q3", lvl(0), 3);
    repeat (48) @(negedge CLK);
    chk("mid_tx_before", int'(tx[0]), 0);
    #2;
    rst_n[0] = 1'b0;
    wr[0] = 1'b1;
    din[0] = 8'h00;
    #1;
    chk("mid_rst_tx", int'(tx[0]), 1);
    chk("mid_rst_level", lvl(0), 0);
    chk("mid_rst_empty", int'(empty[0]), 1);
    chk("mid_rst_busy", int'(busy[0]), 0);
    chk("mid_rst_full", int'(full[0]), 0);
    chk("mid_rst_ovr", int'(ovr[0]), 0);
    repeat (3) @(negedge CLK);
    wr[0] = 1'b0;
    rst_n[0] = 1'b1;
    lows = 0;
    repeat (200) begin
      @(negedge CLK);
      if (!tx[0]) lows++;
    end
    chk("mid_after_lows", lows, 0);
    chk("mid_after_busy", int'(busy[0]), 0);
    chk("mid_after_level", lvl(0), 0);
    single(0, 8'h41, {1'b1, 8'h41, 1'b0}, 10, "8n1");
    single(1, 8'h83, {2'b11, 1'b0, 7'h03, 1'b0}, 11, "7e2");
    single(2, 8'h1F, {1'b1, 1'b0, 5'h1F, 1'b0}, 8, "5o1");
    // overflow on the 4-deep instance: six writes, the sixth is dropped
    fork
      begin
        wr[3] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
          din[3] = 8'(i);
          @(negedge CLK);
          chk($sformatf("ovf_level_w%0d", i), lvl(3), lv_exp[i-1]);
          chk($sformatf("ovf_full_w%0d", i), int'(full[3]), fu_exp[i-1]);
          chk($sformatf("ovf_ovr_w%0d", i), int'(ovr[3]), i == 6 ? 1 : 0);
        end
        wr[3] = 1'b0;
      end
      begin
        repeat (2) @(negedge CLK);
        for (int f = 0; f < 5; f++) begin
          frame(3, {1'b1, 8'(f + 1), 1'b0}, 10, $sformatf("ovf_f%0d", f));
          @(negedge CLK);
        end
      end
    join
    chk("ovf_end_busy", int'(busy[3]), 0);
    chk("ovf_end_level", lvl(3), 0);
    chk("ovf_end_ovr", int'(ovr[3]), 1);
    lows = 0;
    repeat (30) begin
      @(negedge CLK);
      if (!tx[3]) lows++;
    end
    chk("ovf_no_sixth", lows, 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
